k3_sched: RTL and testbench
===========================

# k3_sched

Pass sequencer for the layer-3 kernel weight ROM reader. It walks the kernel index from 0 to `NUM_KIND-1` and, for each index, drives one uninterrupted burst of `k_ready` lasting `KLEN` cycles. It also regenerates data-valid, tap-index and last-tap strobes aligned with the ROM outputs. It sits between the layer-3 convolution control and the weight reader, and gates every pass on the convolution engine's `conv_ready` grant.

## Interface
Parameters:
- `NUM_KIND`, default 64: kernel passes per run (1..128).
- `KLEN`, default 36: taps per pass, equal to the reader's per-index burst length.
- `MULT_LAT`, default 2: latency of the reader's index-to-base-address multiplier.

Ports:
- `clk_in`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a run. Single-cycle pulse; ignored while `busy`.
- `abort`, input, 1: synchronous run cancel.
- `conv_ready`, input, 1: the convolution engine can accept a full `KLEN`-tap burst.
- `k_ready`, output, 1: reader enable/advance.
- `k_ind`, output, 7: kernel index presented to the reader.
- `w_valid`, output, 1: ROM output word valid this cycle.
- `w_tap`, output, 6: tap number of the current ROM word (0..KLEN-1).
- `w_last`, output, 1: the current ROM word is tap `KLEN-1`.
- `busy`, output, 1: a run is in progress.
- `done`, output, 1: one-cycle run-complete pulse.

## Operation
- States: IDLE, SETTLE, WAIT_GNT, STREAM.
- IDLE: `start=1` sets `k_ind` to 0 and moves to SETTLE.
- SETTLE: lasts exactly `MULT_LAT+1` cycles, using a settle counter. This lets the reader's base address recompute and reload while `k_ready=0`. Then move to WAIT_GNT.
- WAIT_GNT: `conv_ready=1` sampled moves to STREAM. Otherwise hold.
- STREAM: `k_ready=1` for exactly `KLEN` consecutive cycles. A tap counter runs 0..KLEN-1.
  - `conv_ready` is not sampled during STREAM. The burst is never paused, because the reader's address reloads whenever `k_ready` drops.
- End of STREAM (tap `KLEN-1`):
  - If `k_ind==NUM_KIND-1`: go to IDLE, and `done` fires as described below.
  - Otherwise: `k_ind` increments on the same edge, and the state goes to SETTLE.
- ROM alignment: `w_valid`, `w_tap` and `w_last` are `k_ready`, the tap counter, and the equality (tap counter == `KLEN-1`), each delayed one register.
- `done` is asserted for 1 cycle, in the same cycle as the final `w_valid`/`w_last`.
- `busy` is high from the cycle after an accepted `start` through the `done` cycle inclusive.
- `abort`:
  - In any non-IDLE state: next state IDLE, `k_ready=0` next cycle, no `done` pulse.
  - An in-flight delayed `w_valid` still completes for one cycle.
  - `k_ind` holds its value.
- `abort` and `start` in the same IDLE cycle: `abort` wins, and the block stays IDLE.
- Counters are sized to `KLEN` and `MULT_LAT`. `k_ind` never exceeds `NUM_KIND-1`; there is no wrap within a run.

## Timing
- Reset values:
  - State IDLE.
  - `k_ready=0`, `k_ind=0`, `w_valid=0`, `w_tap=0`, `w_last=0`, `busy=0`, `done=0`.
  - All counters 0.
- Reset is asynchronous assert and synchronous release. Reset mid-run discards the run; no `done` pulse.
- Start latency: `start` sampled at cycle 0 → SETTLE occupies cycles 1..MULT_LAT+1 → WAIT_GNT at cycle MULT_LAT+2 → first `k_ready` at cycle MULT_LAT+3 if `conv_ready` was already high.
- Per pass with a continuous grant: `MULT_LAT+2+KLEN` cycles.
- `w_valid` lags `k_ready` by exactly 1 cycle.

## Configuration
- `K3_SCHED_STALLCNT_EN`:
  - Defined: adds output `stall_cnt` (16 bits). It counts cycles spent in WAIT_GNT with `conv_ready=0`, saturates at 16'hFFFF, is cleared by an accepted `start`, and resets to 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Nominal run, `NUM_KIND=2`, `KLEN=36`, `MULT_LAT=2`, `conv_ready` tied 1, `start` at cycle 0 → `k_ready` high cycles 5–40 and 45–80; `k_ind=1` from cycle 41; `w_valid` high 6–41 and 46–81; `w_last` at 41 and 81; `done` at 81; `busy` high 1–81.
- Grant stall: as above, but `conv_ready=0` until cycle 10 → first `k_ready` at cycle 11, remaining timing shifted by 6; with `K3_SCHED_STALLCNT_EN`, `stall_cnt=6`.
- `conv_ready` dropped at cycle 20, mid-burst → `k_ready` stays high through cycle 40; tap sequence is unbroken 0..35.
- `abort` at cycle 15 → `k_ready=0` from cycle 16; `w_valid` ends at cycle 16; `busy=0` from cycle 16; no `done`; `k_ind=0`.
- Second `start` pulse during a run (cycle 20) → ignored; the trace is identical to the nominal run.
- `rst_n` low at cycle 30, mid-stream → all outputs 0 immediately; after release, `start` reproduces the nominal timing from the new origin.

Source files
------------

// File: rtl/k3_sched.sv
// ----------------------------------------------------------------------------
// k3_sched -- pass sequencer for the layer-3 kernel weight ROM reader.
//
// The sequencer walks the kernel index from 0 to NUM_KIND-1. For each index
// it runs these steps in order:
//   1. It lets the reader's base-address multiplier settle.
//   2. It waits for the convolution engine's grant.
//   3. It drives one unbroken KLEN-cycle k_ready burst.
// It also rebuilds the valid, tap and last strobes. These are aligned with
// the ROM output word, one register after k_ready.
//
// Optional feature macro: K3_SCHED_STALLCNT_EN
//   When this macro is defined, the block adds the stall_cnt output. It
//   counts WAIT_GNT cycles that have no grant, and saturates at 16'hFFFF.
//
// Ports:
//   clk_in      in   1   single clock
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   run start pulse, ignored while busy
//   abort       in   1   synchronous run cancel
//   conv_ready  in   1   engine can accept a full KLEN-tap burst
//   k_ready     out  1   reader enable/advance
//   k_ind       out  7   kernel index presented to the reader
//   w_valid     out  1   ROM output word valid
//   w_tap       out  6   tap number of the current ROM word
//   w_last      out  1   current ROM word is tap KLEN-1
//   busy        out  1   run in progress (through the done cycle)
//   done        out  1   one-cycle run-complete pulse
//   stall_cnt   out 16   grant stall cycles (K3_SCHED_STALLCNT_EN only)
//
// Handshake: conv_ready is a level grant. It is sampled only in WAIT_GNT.
// When it is sampled high there, the whole KLEN-cycle burst is committed.
// The burst is then never paused, because dropping k_ready would force the
// reader to reload its address.
// ----------------------------------------------------------------------------
module k3_sched #(
    parameter int NUM_KIND = 64,
    parameter int KLEN     = 36,
    parameter int MULT_LAT = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        conv_ready,
    output logic        k_ready,
    output logic [6:0]  k_ind,
    output logic        w_valid,
    output logic [5:0]  w_tap,
    output logic        w_last,
    output logic        busy,
    output logic        done
`ifdef K3_SCHED_STALLCNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int TAP_W = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam int SET_W = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;

    localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(KLEN - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(MULT_LAT);
    localparam logic [6:0]       KIND_LAST = 7'(NUM_KIND - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_WAIT_GNT = 2'd2,
        ST_STREAM   = 2'd3
    } state_t;

    state_t           state_q;
    logic [SET_W-1:0] settle_q;
    logic [TAP_W-1:0] tap_q;
    logic [6:0]       k_ind_q;
    logic             k_ready_q;
    logic             w_valid_q;
    logic [5:0]       w_tap_q;
    logic             w_last_q;
    logic             busy_q;
    logic             done_q;
`ifdef K3_SCHED_STALLCNT_EN
    logic [15:0]      stall_q;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            tap_q     <= '0;
            k_ind_q   <= '0;
            k_ready_q <= 1'b0;
            w_valid_q <= 1'b0;
            w_tap_q   <= '0;
            w_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef K3_SCHED_STALLCNT_EN
            stall_q   <= '0;
`endif
        end else begin
            // The ROM-side strobes are one register behind the reader
            // controls. An aborted burst still delivers its in-flight word.
            w_valid_q <= k_ready_q;
            w_tap_q   <= 6'(tap_q);
            w_last_q  <= k_ready_q && (tap_q == TAP_LAST);
            done_q    <= 1'b0;

`ifdef K3_SCHED_STALLCNT_EN
            if ((state_q == ST_WAIT_GNT) && !conv_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
`endif

            if (abort) begin
                // k_ind deliberately holds its value here.
                state_q   <= ST_IDLE;
                settle_q  <= '0;
                tap_q     <= '0;
                k_ready_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // busy_q is still high only in the done cycle.
                        // A start that arrives in that cycle is ignored.
                        busy_q <= 1'b0;
                        if (start && !busy_q) begin
                            k_ind_q  <= '0;
                            settle_q <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_SETTLE;
`ifdef K3_SCHED_STALLCNT_EN
                            stall_q  <= '0;
`endif
                        end
                    end

                    ST_SETTLE: begin
                        // The SETTLE state lasts MULT_LAT+1 cycles.
                        if (settle_q == SET_LAST) begin
                            settle_q <= '0;
                            state_q  <= ST_WAIT_GNT;
                        end else begin
                            settle_q <= settle_q + SET_W'(1);
                        end
                    end

                    ST_WAIT_GNT: begin
                        if (conv_ready) begin
                            tap_q     <= '0;
                            k_ready_q <= 1'b1;
                            state_q   <= ST_STREAM;
                        end
                    end

                    ST_STREAM: begin
                        if (tap_q == TAP_LAST) begin
                            tap_q     <= '0;
                            k_ready_q <= 1'b0;
                            if (k_ind_q == KIND_LAST) begin
                                // done lines up with the final w_valid/w_last.
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                k_ind_q <= k_ind_q + 7'd1;
                                state_q <= ST_SETTLE;
                            end
                        end else begin
                            tap_q <= tap_q + TAP_W'(1);
                        end
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign k_ready = k_ready_q;
    assign k_ind   = k_ind_q;
    assign w_valid = w_valid_q;
    assign w_tap   = w_tap_q;
    assign w_last  = w_last_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef K3_SCHED_STALLCNT_EN
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_k3_sched.sv
module tb_k3_sched;

    localparam int NK   = 2;
    localparam int KL   = 36;
    localparam int ML   = 2;
    localparam int MAXC = 400;

    logic       clk_in     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start      = 1'b0;
    logic       abort      = 1'b0;
    logic       conv_ready = 1'b0;
    logic       k_ready;
    logic [6:0] k_ind;
    logic       w_valid;
    logic [5:0] w_tap;
    logic       w_last;
    logic       busy;
    logic       done;
`ifdef K3_SCHED_STALLCNT_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Stimulus and the expected per-cycle timeline of one run.
    // Cycle 0 of a run is always the cycle in which start is high.
    bit cr[MAXC];
    bit kr_e[MAXC];
    int tap_e[MAXC];
    int kind_e[MAXC];
    bit busy_e[MAXC];
    bit done_e[MAXC];
    bit wait0_e[MAXC];
    int prev_kind = 0;
    int prev_stall = 0;
    int stall_e = 0;
    int run_len = 0;

    always #5 clk_in = ~clk_in;

    k3_sched #(
        .NUM_KIND (NK),
        .KLEN     (KL),
        .MULT_LAT (ML)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .conv_ready (conv_ready),
        .k_ready    (k_ready),
        .k_ind      (k_ind),
        .w_valid    (w_valid),
        .w_tap      (w_tap),
        .w_last     (w_last),
        .busy       (busy),
        .done       (done)
`ifdef K3_SCHED_STALLCNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Build the timeline from pass-level rules. Each pass has these parts:
    //   - settle for ML+1 cycles;
    //   - wait until the first cycle in which the grant is high;
    //   - a KL-cycle burst that starts on the cycle after that grant.
    // An abort truncates everything after its cycle.
    task automatic build_model(input int abort_c);
        int t;
        int g;
        int last;
        for (int c = 0; c < MAXC; c++) begin
            kr_e[c] = 0; tap_e[c] = 0; kind_e[c] = prev_kind;
            busy_e[c] = 0; done_e[c] = 0; wait0_e[c] = 0;
        end
        stall_e = prev_stall;
        if (abort_c == 0) begin
            run_len = 8;
        end else begin
            t = 1;
            for (int p = 0; p < NK; p++) begin
                for (int c = t; c < MAXC; c++) kind_e[c] = p;
                g = t + ML + 1;
                while (!cr[g] && g < MAXC - KL - 6) begin
                    wait0_e[g] = 1;
                    g++;
                end
                for (int k = 0; k < KL; k++) begin
                    kr_e[g + 1 + k]  = 1;
                    tap_e[g + 1 + k] = k;
                end
                t = g + KL + 1;
            end
            last = t;
            done_e[last] = 1;
            for (int c = 1; c <= last; c++) busy_e[c] = 1;
            run_len = last + 4;
            if (abort_c > 0 && abort_c < last) begin
                for (int c = abort_c + 1; c < MAXC; c++) begin
                    kr_e[c] = 0; tap_e[c] = 0; busy_e[c] = 0; done_e[c] = 0;
                    wait0_e[c] = 0; kind_e[c] = kind_e[abort_c];
                end
                run_len = abort_c + 4;
            end
            stall_e = 0;
            for (int c = 0; c < MAXC; c++) if (wait0_e[c]) stall_e++;
        end
    endtask

    task automatic run_trace(input int extra_start, input int abort_c, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            start      = (c == 0) || (c == extra_start);
            abort      = (c == abort_c);
            conv_ready = cr[c];
            @(negedge clk_in);
            chk("k_ready", c, 16'(k_ready), 16'(kr_e[c]));
            chk("k_ind",   c, 16'(k_ind),   16'(kind_e[c]));
            chk("w_valid", c, 16'(w_valid), (c > 0) ? 16'(kr_e[c-1]) : 16'd0);
            chk("w_tap",   c, 16'(w_tap),   (c > 0) ? 16'(tap_e[c-1]) : 16'd0);
            chk("w_last",  c, 16'(w_last),  (c > 0 && kr_e[c-1] && tap_e[c-1] == KL - 1) ? 16'd1 : 16'd0);
            chk("busy",    c, 16'(busy),    16'(busy_e[c]));
            chk("done",    c, 16'(done),    16'(done_e[c]));
            @(posedge clk_in);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        prev_kind = kind_e[ncyc - 1];
    endtask

    task automatic end_run_checks(input string tag);
`ifdef K3_SCHED_STALLCNT_EN
        chk({tag, "_stall_cnt"}, 0, stall_cnt, 16'(stall_e));
`endif
        prev_stall = stall_e;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_k_ready"}, 0, 16'(k_ready), 16'd0);
        chk({tag, "_k_ind"},   0, 16'(k_ind),   16'd0);
        chk({tag, "_w_valid"}, 0, 16'(w_valid), 16'd0);
        chk({tag, "_w_tap"},   0, 16'(w_tap),   16'd0);
        chk({tag, "_w_last"},  0, 16'(w_last),  16'd0);
        chk({tag, "_busy"},    0, 16'(busy),    16'd0);
        chk({tag, "_done"},    0, 16'(done),    16'd0);
`ifdef K3_SCHED_STALLCNT_EN
        chk({tag, "_stall_cnt"}, 0, stall_cnt, 16'd0);
`endif
    endtask

    initial begin
        int ab;
        int ex;

        // Reset.
        rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;

        // Nominal run with the grant tied high.
        for (int c = 0; c < MAXC; c++) cr[c] = 1;
        build_model(-1);
        run_trace(-1, -1, run_len);
        end_run_checks("nominal");

        // The grant stays low until cycle 10.
        for (int c = 0; c < MAXC; c++) cr[c] = (c >= 10);
        build_model(-1);
        run_trace(-1, -1, run_len);
        end_run_checks("stall");

        // The grant drops in the middle of the first burst.
        for (int c = 0; c < MAXC; c++) cr[c] = !(c >= 20 && c < 40);
        build_model(-1);
        run_trace(-1, -1, run_len);
        end_run_checks("drop");

        // Abort during the first burst.
        for (int c = 0; c < MAXC; c++) cr[c] = 1;
        build_model(15);
        run_trace(-1, 15, run_len);
        end_run_checks("abort");

        // A second start pulse during the run.
        build_model(-1);
        run_trace(20, -1, run_len);
        end_run_checks("restart");

        // Abort and start in the same idle cycle.
        build_model(0);
        run_trace(-1, 0, run_len);
        end_run_checks("abort_start");

        // Reset mid-stream, then a fresh nominal run.
        build_model(-1);
        run_trace(-1, -1, 30);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk_in);
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        prev_kind = 0;
        prev_stall = 0;
        build_model(-1);
        run_trace(-1, -1, run_len);
        end_run_checks("post_reset");

        // Random grant patterns, each with an optional abort or an ignored restart.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < MAXC; c++) cr[c] = ($urandom_range(0, 99) < 55) || (c >= 300);
            ab = -1;
            ex = -1;
            case ($urandom_range(0, 2))
                0: ab = $urandom_range(1, 70);
                1: ex = $urandom_range(1, 39);
                default: ;
            endcase
            build_model(ab);
            run_trace(ex, ab, run_len);
            end_run_checks("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
